// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush control for branch, load-use, imem wait and (with MULDIV_STALL_EN) multi-cycle muldiv
module hazard_stall_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_muldiv,
  input  logic        branch_taken_ex,
  input  logic        imem_ready,
  output logic        stall,
  output logic        stall_ifid,
  output logic        hold_ex,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [31:0] stall_cycles
);
  if (MULDIV_CYCLES < 2 || MULDIV_CYCLES > 255) begin : g_bad_cycles
    $error("MULDIV_CYCLES must be in 2..255");
  end
  logic [4:0]  ctrl;
  logic        load_use;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  assign load_use = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  assign {stall, stall_ifid, hold_ex, flush_ifid, flush_idex} = ctrl;
  assign stall_cycles = stall_cycles_q;
`ifdef MULDIV_STALL_EN
  localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES - 1);
  typedef enum logic {RUN, MULDIV} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  // control outputs by priority; a running muldiv ignores every input until its last cycle
  always_comb begin
    ctrl = rst ? 5'b00000
         : state_q == MULDIV ? (cnt_q > 8'd1 ? 5'b11100 : 5'b00000)
         : branch_taken_ex ? 5'b00011
         : ex_muldiv ? 5'b11100
         : load_use || !imem_ready ? 5'b11001
         : 5'b00000;
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == MULDIV) begin
      state_d = cnt_q > 8'd1 ? MULDIV : RUN;
      cnt_d = cnt_q - 8'd1;
    end else if (!branch_taken_ex && ex_muldiv) begin
      state_d = MULDIV;
      cnt_d = CNT_INIT;
    end
  end
  // muldiv sequencer state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_muldiv;
  assign unused_muldiv = ex_muldiv;
  // control outputs by priority, muldiv stalls compiled out
  always_comb begin
    ctrl = rst ? 5'b00000
         : branch_taken_ex ? 5'b00011
         : load_use || !imem_ready ? 5'b11001
         : 5'b00000;
  end
`endif
  // saturating count of stalled cycles
  always_comb begin
    stall_cycles_d = stall && stall_cycles_q != 32'hFFFF_FFFF ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end
  // stall counter register
  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= 32'd0;
    else stall_cycles_q <= stall_cycles_d;
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with a per-cycle behavioural model and literal spot checks
module tb_hazard_stall_ctrl;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, br, md, mr, rdy;
  logic [4:0] rd, rs1, rs2;
  logic stall, stall_ifid, hold_ex, flush_ifid, flush_idex;
  logic [31:0] sc;
  logic [4:0] ctrl;
  logic pre_en;
  logic [31:0] pre_val;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  assign ctrl = {stall, stall_ifid, hold_ex, flush_ifid, flush_idex};

  hazard_stall_ctrl #(.MULDIV_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .ex_rd(rd), .ex_mem_read(mr),
    .ex_muldiv(md), .branch_taken_ex(br), .imem_ready(rdy), .stall(stall),
    .stall_ifid(stall_ifid), .hold_ex(hold_ex), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .stall_cycles(sc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic m, input logic r, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic y);
    br = b; md = m; mr = r; rd = d; rs1 = s1; rs2 = s2; rdy = y;
  endtask

  // model: remaining cycles of an in-flight muldiv (last one is the release cycle) and the stall total
  initial begin
    int left;
    logic [31:0] m_sc, base;
    logic [4:0] e;
    logic lu;
    left = 0;
    m_sc = 0;
    forever begin
      @(negedge clk);
      lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
      if (rst) e = 5'b00000;
`ifdef MULDIV_STALL_EN
      else if (left > 0) e = left > 1 ? 5'b11100 : 5'b00000;
`endif
      else if (br) e = 5'b00011;
`ifdef MULDIV_STALL_EN
      else if (md) e = 5'b11100;
`endif
      else if (lu || !rdy) e = 5'b11001;
      else e = 5'b00000;
      chk("m_stall", 32'(stall), 32'(e[4]));
      chk("m_stall_ifid", 32'(stall_ifid), 32'(e[3]));
      chk("m_hold_ex", 32'(hold_ex), 32'(e[2]));
      chk("m_flush_ifid", 32'(flush_ifid), 32'(e[1]));
      chk("m_flush_idex", 32'(flush_idex), 32'(e[0]));
      chk("m_stall_cycles", sc, pre_en ? pre_val : m_sc);
      @(posedge clk);
      base = pre_en ? pre_val : m_sc;
      m_sc = rst ? 32'd0 : (e[4] && base != 32'hFFFF_FFFF) ? base + 32'd1 : base;
`ifdef MULDIV_STALL_EN
      if (rst) left = 0;
      else if (left > 0) left--;
      else if (!br && md) left = N - 1;
`endif
    end
  end

  initial begin
    logic [11:0] vec [8];
    vec = '{12'b0_1_0_0_1_0_1_0_0_1_1_1, 12'b0_0_0_0_0_0_0_0_0_0_0_0, 12'b1_1_0_0_0_0_0_0_0_0_1_0,
            12'b0_0_1_0_1_0_1_0_0_1_0_1, 12'b0_1_1_0_0_1_1_0_0_0_1_1, 12'b0_0_0_0_0_0_0_0_0_0_0_1,
            12'b0_0_0_0_0_0_0_0_0_0_0_0, 12'b0_1_0_0_0_0_0_0_0_0_0_1};
    rst = 1; pre_en = 0; pre_val = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    tick(); tick();
    @(negedge clk); chk("rst_ctrl", 32'(ctrl), 0); chk("rst_sc", sc, 0);
    tick(); rst = 0;
    @(negedge clk); chk("idle_ctrl", 32'(ctrl), 0);
    tick(); drive(0, 0, 1, 5, 3, 5, 1);
    @(negedge clk); chk("lu_rs2_ctrl", 32'(ctrl), 32'h19); chk("lu_sc_before", sc, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("lu_sc_after", sc, 1); chk("lu_done_ctrl", 32'(ctrl), 0);
    tick(); drive(0, 0, 1, 0, 0, 0, 1);
    @(negedge clk); chk("x0_ctrl", 32'(ctrl), 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("x0_sc", sc, 1);
    tick(); drive(0, 0, 1, 7, 7, 1, 1);
    @(negedge clk); chk("lu_rs1_ctrl", 32'(ctrl), 32'h19);
    tick(); drive(0, 0, 0, 7, 7, 1, 1);
    @(negedge clk); chk("noload_ctrl", 32'(ctrl), 0); chk("lu_rs1_sc", sc, 2);
    tick(); drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("imem_ctrl", 32'(ctrl), 32'h19);
    tick(); drive(1, 0, 1, 5, 0, 5, 0);
    @(negedge clk); chk("br_ctrl", 32'(ctrl), 32'h03); chk("imem_sc", sc, 3);
    tick(); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("br_sc", sc, 3);
`ifdef MULDIV_STALL_EN
    tick(); drive(0, 1, 1, 5, 0, 5, 1);
    @(negedge clk); chk("md1_ctrl", 32'(ctrl), 32'h1C);
    tick(); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("md2_ctrl", 32'(ctrl), 32'h1C);
    tick(); drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("md3_ignore_ctrl", 32'(ctrl), 32'h1C);
    tick(); drive(0, 1, 0, 0, 0, 0, 1);
    @(negedge clk); chk("md_release_ctrl", 32'(ctrl), 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("md_sc", sc, 6); chk("md_after_ctrl", 32'(ctrl), 0);
    tick(); drive(0, 1, 0, 0, 0, 0, 1);
    @(negedge clk); chk("mdr_start_ctrl", 32'(ctrl), 32'h1C);
    tick(); drive(0, 0, 0, 0, 0, 0, 1); rst = 1;
`else
    tick(); drive(0, 1, 0, 0, 0, 0, 1);
    @(negedge clk); chk("md_off_ctrl", 32'(ctrl), 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("md_off_sc", sc, 3);
    tick(); rst = 1;
`endif
    @(negedge clk); chk("rst_md_ctrl", 32'(ctrl), 0);
    tick(); rst = 0; drive(0, 0, 1, 9, 9, 0, 1);
    @(negedge clk); chk("rst_md_run_ctrl", 32'(ctrl), 32'h19); chk("rst_md_sc", sc, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); chk("rst_md_sc_after", sc, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(vec[i][11], vec[i][10], vec[i][9], vec[i][8:4], vec[i][3:0] == 4'd0 ? 5'd0 : 5'(vec[i][3:1]), 5'(vec[i][8:4]), vec[i][0]);
    end
    repeat (N) begin tick(); drive(0, 0, 0, 0, 0, 0, 1); end
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cycles_q;
    pre_val = 32'hFFFF_FFFE; pre_en = 1; rdy = 0;
    @(negedge clk); chk("sat_preload", sc, 32'hFFFF_FFFE);
    tick(); pre_en = 0;
    @(negedge clk); chk("sat_max", sc, 32'hFFFF_FFFF);
    tick();
    @(negedge clk); chk("sat_hold", sc, 32'hFFFF_FFFF);
    tick(); rdy = 1;
    @(negedge clk); chk("sat_final", sc, 32'hFFFF_FFFF);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4 (legal range 2..255): total cycles a multiply/divide instruction occupies EX.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 SHALL have ports ex_rd (input, 5) and ex_mem_read (input, 1): destination register of the EX instruction and its is-load flag.
REQ-006 SHALL have port ex_muldiv  input  1  EX holds a multi-cycle multiply/divide.
REQ-007 SHALL have port branch_taken_ex  input  1  EX resolved a taken branch or jump.
REQ-008 SHALL have port imem_ready  input  1  instruction memory returns valid data this cycle.
REQ-009 SHALL have port stall  output  1  freezes the PC register (drives its stall input).
REQ-010 SHALL have ports stall_ifid (output, 1) and hold_ex (output, 1): freeze the IF/ID and ID/EX registers respectively.
REQ-011 SHALL have ports flush_ifid, flush_idex  output  1 each  insert a bubble into IF/ID and ID/EX.
REQ-012 SHALL have port stall_cycles  output  32  count of cycles with stall=1.

Function
REQ-013 SHALL implement states RUN and MULDIV plus an 8-bit down-counter cnt.
REQ-014 In RUN, SHALL evaluate conditions combinationally in strict priority: branch_taken_ex > ex_muldiv > load-use > !imem_ready > none.
REQ-015 Branch: flush_ifid=1, flush_idex=1, stall=0, stall_ifid=0, hold_ex=0; the PC loads the redirect target.
REQ-016 Muldiv start: stall=stall_ifid=hold_ex=1, flushes 0; cnt<=MULDIV_CYCLES-1; next state MULDIV.
REQ-017 Load-use: defined as ex_mem_read=1 and ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2); outputs stall=stall_ifid=flush_idex=1, all others 0; remains in RUN.
REQ-018 !imem_ready: stall=stall_ifid=flush_idex=1, all others 0.
REQ-019 None: all control outputs 0.
REQ-020 In MULDIV with cnt>1: stall=stall_ifid=hold_ex=1, flushes 0, cnt decrements; all other inputs are ignored.
REQ-021 In MULDIV with cnt==1: all control outputs 0, next state RUN; the muldiv instruction leaves EX at this edge and is not restarted.
REQ-022 Result: exactly MULDIV_CYCLES-1 stalled cycles per muldiv instruction.
REQ-023 stall_cycles SHALL increment by 1 on every edge where stall=1 and saturate at 32'hFFFFFFFF.

Reset
REQ-024 rst=1 at a posedge SHALL force state RUN, cnt=0 and stall_cycles=0, overriding all other behaviour including an active MULDIV sequence.
REQ-025 While rst=1, all control outputs SHALL be 0.

Configuration
REQ-026 Macro MULDIV_STALL_EN defined: MULDIV state, cnt and hold_ex behave per REQ-016..REQ-022.
REQ-027 Macro MULDIV_STALL_EN undefined: ex_muldiv is ignored, hold_ex is tied 0, no MULDIV state or counter exists, and priority becomes branch > load-use > !imem_ready.

Verification
REQ-028 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> stall=stall_ifid=flush_idex=1 for 1 cycle; stall_cycles increments 0->1.
REQ-029 x0 load: ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall, stall_cycles unchanged.
REQ-030 Branch concurrent with load-use and !imem_ready -> flush_ifid=flush_idex=1, stall=0.
REQ-031 Muldiv (MULDIV_CYCLES=4): ex_muldiv=1 for 1 cycle -> stall=hold_ex=1 for exactly 3 cycles, then 0; stall_cycles=3.
REQ-032 Reset during a muldiv: rst=1 in the second MULDIV cycle -> next cycle state RUN, outputs 0, stall_cycles=0.
REQ-033 Saturation: preload to 32'hFFFFFFFE, 3 stall cycles -> stall_cycles holds 32'hFFFFFFFF.
